// File: rtl/data_memory_hs.sv
// rtl/data_memory_hs.sv - handshaked data memory with byte strobes, read latency and clear
//
// Purpose: single-outstanding-request data memory. Each accepted request gets one
// response after a fixed latency: read data, or a zero-data write acknowledge.
// Out-of-range addresses get resp_err=1 and never touch the array.
//
// Ports:
//   clk         clock, rising edge
//   rst_n       asynchronous active-low reset
//   req_valid   request present
//   req_ready   block can accept a request (IDLE only, low while in reset)
//   req_write   1 = write, 0 = read
//   req_addr    word address
//   req_wdata   write data
//   req_wstrb   byte enables, bit i covers wdata[8i+7:8i]
//   resp_valid  response present
//   resp_ready  consumer accepts the response
//   resp_rdata  read data, 0 for writes and errors
//   resp_err    address was >= DEPTH

module data_memory_hs #(
  parameter int WORDSIZE       = 64,
  parameter int DEPTH          = 32,
  parameter int ADDR_W         = 5,
  parameter int READ_LATENCY   = 1,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [WORDSIZE-1:0]   req_wdata,
  input  logic [WORDSIZE/8-1:0] req_wstrb,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [WORDSIZE-1:0]   resp_rdata,
  output logic                  resp_err
);

  localparam int                NBYTES    = WORDSIZE / 8;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [31:0]       DEPTH_U   = 32'(DEPTH);
  localparam logic [1:0]        WAIT_INIT = 2'(READ_LATENCY - 1);

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_WAIT, S_RESP} state_t;

  localparam state_t RESET_STATE = CLEAR_ON_RESET ? S_CLEAR : S_IDLE;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   clr_ptr, clr_ptr_nxt;
  logic [1:0]          cnt, cnt_nxt;
  logic [WORDSIZE-1:0] rdata_q, rdata_nxt;
  logic                err_q, err_nxt;
  logic                accept;
  logic                addr_err;

  logic [WORDSIZE-1:0] mem [DEPTH];

  // rst_n is folded in so that a CLEAR_ON_RESET=0 build does not advertise
  // readiness while reset is still asserted.
  assign req_ready  = rst_n && (state == S_IDLE);
  assign accept     = req_valid && req_ready;
  assign addr_err   = 32'(req_addr) >= DEPTH_U;

  assign resp_valid = (state == S_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RESET_STATE;
      clr_ptr <= '0;
      cnt     <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      clr_ptr <= clr_ptr_nxt;
      cnt     <= cnt_nxt;
      rdata_q <= rdata_nxt;
      err_q   <= err_nxt;
    end
  end

  // cnt holds the number of WAIT cycles still to spend after the current one;
  // RESP is entered on the edge where it is already zero.
  always_comb begin
    state_nxt   = state;
    clr_ptr_nxt = clr_ptr;
    cnt_nxt     = cnt;
    rdata_nxt   = rdata_q;
    err_nxt     = err_q;
    case (state)
      S_CLEAR: begin
        clr_ptr_nxt = clr_ptr + 1'b1;
        if (clr_ptr == LAST_ADDR) begin
          clr_ptr_nxt = '0;
          state_nxt   = S_IDLE;
        end
      end
      S_IDLE: begin
        if (accept) begin
          err_nxt   = addr_err;
          rdata_nxt = (!req_write && !addr_err) ? mem[req_addr] : '0;
          if (READ_LATENCY == 1) begin
            state_nxt = S_RESP;
          end else begin
            state_nxt = S_WAIT;
            cnt_nxt   = WAIT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt == 2'd0) begin
          state_nxt = S_RESP;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          state_nxt = S_IDLE;
          rdata_nxt = '0;
          err_nxt   = 1'b0;
        end
      end
      default: state_nxt = RESET_STATE;
    endcase
  end

  // Array has no reset; the clear sweep is the only way it gets zeroed.
  always_ff @(posedge clk) begin
    if (rst_n && (state == S_CLEAR)) begin
      mem[clr_ptr] <= '0;
    end else if (accept && req_write && !addr_err) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (req_wstrb[i]) begin
          mem[req_addr][8*i +: 8] <= req_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_memory_hs.sv
// tb/tb_data_memory_hs.sv - self-checking bench for data_memory_hs

module tb_data_memory_hs;

  localparam int WS    = 64;
  localparam int DEPTH = 24;
  localparam int AW    = 5;
  localparam int LAT   = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [WS-1:0] req_wdata = '0;
  logic [7:0]    req_wstrb = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b0;
  logic [WS-1:0] resp_rdata;
  logic          resp_err;

  always #5 clk = ~clk;

  data_memory_hs #(
    .WORDSIZE(WS), .DEPTH(DEPTH), .ADDR_W(AW),
    .READ_LATENCY(LAT), .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  logic [63:0] model [DEPTH];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_clear();
    int n = 0;
    while (!req_ready && n < 200) begin
      chk("clear_no_resp", resp_valid, 1'b0);
      tick();
      n++;
    end
    chk("clear_cycles", n, DEPTH);
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_req_ready", req_ready, 1'b0);
    chk("rst_rdata", resp_rdata, '0);
    chk("rst_err", resp_err, 1'b0);
    tick();
    chk("rst_hold_ready", req_ready, 1'b0);
    rst_n = 1'b1;
    wait_clear();
  endtask

  task automatic xact(input bit wr, input logic [AW-1:0] addr, input logic [63:0] wd,
                      input logic [7:0] ws, input int stall);
    bit          exp_err;
    logic [63:0] exp_rd;
    int          n;
    exp_err = (int'(addr) >= DEPTH);
    exp_rd  = (!wr && !exp_err) ? model[addr] : 64'd0;
    if (wr && !exp_err)
      for (int b = 0; b < 8; b++)
        if (ws[b]) model[addr][8*b +: 8] = wd[8*b +: 8];
    chk("idle_ready", req_ready, 1'b1);
    req_valid  = 1'b1;
    req_write  = wr;
    req_addr   = addr;
    req_wdata  = wd;
    req_wstrb  = ws;
    resp_ready = 1'b0;
    tick();
    // Junk on the request bus after acceptance must be ignored.
    req_valid = 1'b0;
    req_write = 1'($urandom);
    req_addr  = AW'($urandom);
    req_wdata = {$urandom, $urandom};
    req_wstrb = 8'($urandom);
    n = 0;
    while (!resp_valid && n < 20) begin
      chk("busy_ready", req_ready, 1'b0);
      tick();
      n++;
    end
    chk("latency", n, LAT);
    chk("rdata", resp_rdata, exp_rd);
    chk("err", resp_err, exp_err);
    for (int k = 0; k < stall; k++) begin
      req_valid = 1'($urandom);
      req_write = 1'b1;
      req_addr  = AW'($urandom_range(0, DEPTH - 1));
      req_wdata = {$urandom, $urandom};
      req_wstrb = 8'hFF;
      tick();
      chk("stall_valid", resp_valid, 1'b1);
      chk("stall_rdata", resp_rdata, exp_rd);
      chk("stall_err", resp_err, exp_err);
      chk("stall_ready", req_ready, 1'b0);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk("hs_valid", resp_valid, 1'b0);
    chk("hs_ready", req_ready, 1'b1);
    chk("hs_rdata", resp_rdata, '0);
    chk("hs_err", resp_err, 1'b0);
  endtask

  initial begin
    int n;
    do_reset();

    for (int a = 0; a < DEPTH; a++) xact(1'b0, AW'(a), '0, '0, 0);

    xact(1'b1, 5'd5, 64'h1122334455667788, 8'hFF, 0);
    xact(1'b1, 5'd5, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 1);
    xact(1'b0, 5'd5, '0, '0, 0);
    chk("strobe_merge_model", model[5], 64'h11223344AAAAAAAA);

    xact(1'b0, 5'd5, '0, '0, 5);

    xact(1'b1, 5'd2, 64'h0123456789ABCDEF, 8'hFF, 0);
    xact(1'b1, 5'd26, 64'hDEADBEEFDEADBEEF, 8'hFF, 0);
    xact(1'b0, 5'd2, '0, '0, 0);
    xact(1'b0, 5'd31, '0, '0, 2);
    xact(1'b1, 5'd9, 64'hFFFFFFFFFFFFFFFF, 8'h00, 0);
    xact(1'b0, 5'd9, '0, '0, 0);

    for (int t = 0; t < 150; t++)
      xact(1'($urandom), AW'($urandom), {$urandom, $urandom}, 8'($urandom),
           int'($urandom_range(0, 3)));

    // Reset while waiting for a read response.
    xact(1'b1, 5'd5, 64'h5555AAAA5555AAAA, 8'hFF, 0);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 5'd5;
    tick();
    req_valid = 1'b0;
    tick();
    do_reset();
    xact(1'b0, 5'd5, '0, '0, 0);
    xact(1'b0, 5'd0, '0, '0, 0);

    // Reset while a read response is being presented.
    xact(1'b1, 5'd7, 64'h0F0F0F0F0F0F0F0F, 8'hFF, 0);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 5'd7;
    tick();
    req_valid = 1'b0;
    n = 0;
    while (!resp_valid && n < 20) begin tick(); n++; end
    chk("pre_rst_resp", resp_valid, 1'b1);
    do_reset();
    xact(1'b0, 5'd7, '0, '0, 0);
    xact(1'b0, 5'd23, '0, '0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
